fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the LEGv8 5-stage pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction into the IF/ID register.
- Obeys the load-use stall controls (PCWrite, IF_ID_Write) from the hazard control unit and the branch redirect from the MEM stage. Its outputs feed decode, whose Rs1_D/Rs2_D return to the hazard unit.

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LEGv8 IF stage with IF/ID pipeline register: PC, stall/redirect handling, misaligned-target flag.
// Optional FETCH_PERF_CNT_EN adds saturating stall and flush counters.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               branch_taken_M,
    input  logic [ADDR_W-1:0]  branch_target_M,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_F,
    output logic [ADDR_W-1:0]  pc_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic               valid_D,
    output logic               fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
`endif
);

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] redirect_pc;
    logic              target_misaligned;

    assign redirect_pc       = {branch_target_M[ADDR_W-1:2], 2'b00};
    assign target_misaligned = |branch_target_M[1:0];
    assign imem_addr         = pc_F;

    always_comb begin
        pc_next = pc_F + ADDR_W'(PC_INC);
        if (branch_taken_M)
            pc_next = redirect_pc;
        else if (!PCWrite)
            pc_next = pc_F;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F        <= RESET_PC;
            fetch_fault <= 1'b0;
        end else begin
            pc_F <= pc_next;
            if (branch_taken_M && target_misaligned)
                fetch_fault <= 1'b1;
        end
    end

    // A redirect flushes IF/ID even during a stall: the held instruction is on the wrong path.
    always_ff @(posedge clk) begin
        if (reset || branch_taken_M) begin
            pc_D    <= '0;
            instr_D <= '0;
            valid_D <= 1'b0;
        end else if (IF_ID_Write) begin
            pc_D    <= pc_F;
            instr_D <= imem_rdata;
            valid_D <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PCWrite && !branch_taken_M && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken_M && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, stall, redirect, fault, wrap, optional counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        branch_taken_M;
    logic [63:0] branch_target_M;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] pc_F;
    logic [63:0] pc_D;
    logic [31:0] instr_D;
    logic        valid_D;
    logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    // Second instance exercising the wrap-around reset vector.
    logic        w_reset;
    logic [63:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic [63:0] w_pc_F;
    logic [63:0] w_pc_D;
    logic [31:0] w_instr_D;
    logic        w_valid_D;
    logic        w_fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] w_stall_cycles;
    logic [31:0] w_flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = 32'hA0 + imem_addr[31:0];
    assign w_imem_rdata = 32'hA0 + w_imem_addr[31:0];

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .branch_taken_M  (branch_taken_M),
        .branch_target_M (branch_target_M),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_F            (pc_F),
        .pc_D            (pc_D),
        .instr_D         (instr_D),
        .valid_D         (valid_D),
        .fetch_fault     (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_wrap (
        .clk             (clk),
        .reset           (w_reset),
        .PCWrite         (1'b1),
        .IF_ID_Write     (1'b1),
        .branch_taken_M  (1'b0),
        .branch_target_M (64'h0),
        .imem_addr       (w_imem_addr),
        .imem_rdata      (w_imem_rdata),
        .pc_F            (w_pc_F),
        .pc_D            (w_pc_D),
        .instr_D         (w_instr_D),
        .valid_D         (w_valid_D),
        .fetch_fault     (w_fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles    (w_stall_cycles),
        .flush_count     (w_flush_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [63:0] epc_f, input logic [63:0] epc_d,
                            input logic [31:0] einstr, input logic evalid);
        check({tag, ".pc_F"},    pc_F,    epc_f);
        check({tag, ".pc_D"},    pc_D,    epc_d);
        check({tag, ".instr_D"}, {32'h0, instr_D}, {32'h0, einstr});
        check({tag, ".valid_D"}, {63'h0, valid_D}, {63'h0, evalid});
    endtask

    initial begin
        reset           = 1'b1;
        w_reset         = 1'b1;
        PCWrite         = 1'b1;
        IF_ID_Write     = 1'b1;
        branch_taken_M  = 1'b0;
        branch_target_M = 64'h0;
        step();
        step();
        check_if("reset", 64'h0, 64'h0, 32'h0, 1'b0);
        check("reset.fault", {63'h0, fetch_fault}, 64'h0);

        // Free-running fetch
        reset = 1'b0;
        step();
        check_if("run1", 64'h4, 64'h0, 32'hA0, 1'b1);
        check("run1.imem_addr", imem_addr, 64'h4);
        step();
        check_if("run2", 64'h8, 64'h4, 32'hA4, 1'b1);

        // Full load-use stall for two cycles
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        step();
        check_if("stall1", 64'h8, 64'h4, 32'hA4, 1'b1);
        step();
        check_if("stall2", 64'h8, 64'h4, 32'hA4, 1'b1);
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        step();
        check_if("release", 64'hC, 64'h8, 32'hA8, 1'b1);

        // Redirect while the PC is stalled
        PCWrite         = 1'b0;
        branch_taken_M  = 1'b1;
        branch_target_M = 64'h100;
        step();
        check_if("redir", 64'h100, 64'h0, 32'h0, 1'b0);
        check("redir.fault", {63'h0, fetch_fault}, 64'h0);
        PCWrite        = 1'b1;
        branch_taken_M = 1'b0;
        step();
        check_if("redir+1", 64'h104, 64'h100, 32'h1A0, 1'b1);

        // PC held, IF/ID reloading the same instruction
        PCWrite = 1'b0;
        step();
        check_if("decoup1", 64'h104, 64'h104, 32'h1A4, 1'b1);
        step();
        check_if("decoup2", 64'h104, 64'h104, 32'h1A4, 1'b1);
        PCWrite = 1'b1;

        // Misaligned redirect with IF/ID hold: flush still wins
        IF_ID_Write     = 1'b0;
        branch_taken_M  = 1'b1;
        branch_target_M = 64'h102;
        step();
        check_if("misal", 64'h100, 64'h0, 32'h0, 1'b0);
        check("misal.fault", {63'h0, fetch_fault}, 64'h1);
        IF_ID_Write    = 1'b1;
        branch_taken_M = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("sticky%0d", i), {63'h0, fetch_fault}, 64'h1);
        end
        check("sticky.pc_F", pc_F, 64'h100 + 64'd40);

        // Reset during stall and redirect discards everything
        reset           = 1'b1;
        PCWrite         = 1'b0;
        IF_ID_Write     = 1'b0;
        branch_taken_M  = 1'b1;
        branch_target_M = 64'h203;
        step();
        check_if("midreset", 64'h0, 64'h0, 32'h0, 1'b0);
        check("midreset.fault", {63'h0, fetch_fault}, 64'h0);
        reset          = 1'b0;
        PCWrite        = 1'b1;
        IF_ID_Write    = 1'b1;
        branch_taken_M = 1'b0;
        step();
        check_if("postreset", 64'h4, 64'h0, 32'hA0, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1;
        step();
        reset   = 1'b0;
        PCWrite = 1'b0;
        for (int i = 0; i < 4; i++) step();
        branch_taken_M  = 1'b1;
        branch_target_M = 64'h40;
        step();
        branch_taken_M = 1'b0;
        step();
        PCWrite        = 1'b1;
        branch_taken_M = 1'b1;
        step();
        branch_taken_M = 1'b0;
        step();
        check("perf.stall", {32'h0, stall_cycles}, 64'd5);
        check("perf.flush", {32'h0, flush_count},  64'd2);
        reset = 1'b1;
        step();
        check("perf.rst_stall", {32'h0, stall_cycles}, 64'd0);
        check("perf.rst_flush", {32'h0, flush_count},  64'd0);
        reset = 1'b0;
`endif

        // Wrap-around from the top of the address space
        step();
        check("wrap.rst", w_pc_F, 64'hFFFF_FFFF_FFFF_FFF8);
        w_reset = 1'b0;
        step();
        check("wrap1", w_pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap1.pc_D", w_pc_D, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("wrap2", w_pc_F, 64'h0);
        step();
        check("wrap3", w_pc_F, 64'h4);
        check("wrap3.pc_D", w_pc_D, 64'h0);
        check("wrap.fault", {63'h0, w_fetch_fault}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
